ifm_serial_driver: RTL

- Transmit-side companion to the bit-serial convolution core.
- Accepts 32 parallel IFM pixels from an upstream controller, one per handshake, into an internal buffer.
- Streams the buffered pixels to the core's 32 serial IFM lanes under in_valid, then waits for the core's out_valid / Out_OFM result.
- Returns the result upstream through a valid/ready response port, with timeout and protocol-error reporting.

---
 rtl/cim_pkg.sv | 17 +
 rtl/ifm_lane_buffer.sv | 35 +++
 rtl/ifm_serial_driver.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cim_pkg.sv
// Shared constants and state encoding for the bit-serial convolution
// interface blocks.
package cim_pkg;

  localparam int CIM_LANES   = 32;
  localparam int CIM_IFM_W   = 8;
  localparam int CIM_OFM_W   = 13;
  localparam int CIM_TIMEOUT = 255;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/ifm_lane_buffer.sv
// LANES x IFM_W pixel register file. One pixel is written per cycle by
// lane index; reads return one bit position across all lanes, which is
// exactly the vector the serial lanes need in a given bit cycle.
module ifm_lane_buffer
  import cim_pkg::*;
#(
  parameter int LANES = CIM_LANES,
  parameter int IFM_W = CIM_IFM_W
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(LANES)-1:0] i_wr_idx,
  input  logic [IFM_W-1:0]         i_wr_data,
  input  logic [$clog2(IFM_W)-1:0] i_rd_bit,
  output logic [LANES-1:0]         o_rd_slice
);

  logic [IFM_W-1:0] r_mem [LANES];

  // Pixel storage; contents are always rewritten before use, so no reset
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  // Bit-slice read: lane i contributes bit i_rd_bit of its pixel
  always_comb begin
    o_rd_slice = '0;
    for (int i = 0; i < LANES; i++) begin
      o_rd_slice[i] = r_mem[i][i_rd_bit];
    end
  end

endmodule

// File: rtl/ifm_serial_driver.sv
// Transmit-side driver for the bit-serial convolution core: collects LANES
// pixels from upstream, shifts them out LSB first on the serial lanes,
// waits for the core result (with timeout) and hands it back upstream.
module ifm_serial_driver
  import cim_pkg::*;
#(
  parameter int LANES   = CIM_LANES,
  parameter int IFM_W   = CIM_IFM_W,
  parameter int OFM_W   = CIM_OFM_W,
  parameter int TIMEOUT = CIM_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IFM_W-1:0] s_data,
  output logic             in_valid,
  output logic [LANES-1:0] ifm_bits,
  input  logic             out_valid,
  input  logic [OFM_W-1:0] Out_OFM,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OFM_W-1:0] m_data,
  output logic             m_err,
  output logic             proto_err
);

  localparam int IDX_W = $clog2(LANES);
  localparam int BIT_W = $clog2(IFM_W);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(IFM_W - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_load_cnt, w_load_cnt_nxt;
  logic [BIT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic [TMO_W-1:0]   r_tmo_cnt, w_tmo_cnt_nxt;
  logic               r_in_valid, w_in_valid_nxt;
  logic [LANES-1:0]   r_ifm_bits, w_ifm_bits_nxt;
  logic               r_m_valid, w_m_valid_nxt;
  logic [OFM_W-1:0]   r_m_data, w_m_data_nxt;
  logic               r_m_err, w_m_err_nxt;
  logic               r_proto_err, w_proto_err_nxt;

  logic               w_load_hs;
  logic               w_resp_hs;
  logic [BIT_W-1:0]   w_rd_bit;
  logic [LANES-1:0]   w_slice;
  logic [LANES-1:0]   w_first_slice;

  assign s_ready   = (r_state == S_LOAD);
  assign w_load_hs = s_valid && s_ready;
  assign w_resp_hs = r_m_valid && m_ready;

  // While sending, look one bit ahead so the registered lanes carry bit k in cycle k
  assign w_rd_bit = (r_state == S_SEND) ? (r_bit_cnt + BIT_W'(1)) : '0;

  ifm_lane_buffer #(
    .LANES (LANES),
    .IFM_W (IFM_W)
  ) u_buf (
    .clk        (clk),
    .i_wr_en    (w_load_hs),
    .i_wr_idx   (r_load_cnt),
    .i_wr_data  (s_data),
    .i_rd_bit   (w_rd_bit),
    .o_rd_slice (w_slice)
  );

  // Bit 0 of the first frame cycle: the last lane is still being written, so bypass it
  always_comb begin
    w_first_slice            = w_slice;
    w_first_slice[LANES-1]   = s_data[0];
  end

  // Next-state and next-output logic for the LOAD/SEND/WAIT/RESP sequence
  always_comb begin
    w_state_nxt     = r_state;
    w_load_cnt_nxt  = r_load_cnt;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_tmo_cnt_nxt   = r_tmo_cnt;
    w_in_valid_nxt  = 1'b0;
    w_ifm_bits_nxt  = '0;
    w_m_valid_nxt   = r_m_valid;
    w_m_data_nxt    = r_m_data;
    w_m_err_nxt     = r_m_err;
    w_proto_err_nxt = r_proto_err | (out_valid && (r_state != S_WAIT));

    case (r_state)
      S_LOAD: begin
        if (w_load_hs) begin
          if (r_load_cnt == LAST_IDX) begin
            w_load_cnt_nxt = '0;
            w_bit_cnt_nxt  = '0;
            w_in_valid_nxt = 1'b1;
            w_ifm_bits_nxt = w_first_slice;
            w_state_nxt    = S_SEND;
          end else begin
            w_load_cnt_nxt = r_load_cnt + IDX_W'(1);
          end
        end
      end
      S_SEND: begin
        if (r_bit_cnt == LAST_BIT) begin
          w_bit_cnt_nxt = '0;
          w_tmo_cnt_nxt = '0;
          w_state_nxt   = S_WAIT;
        end else begin
          w_bit_cnt_nxt  = r_bit_cnt + BIT_W'(1);
          w_in_valid_nxt = 1'b1;
          w_ifm_bits_nxt = w_slice;
        end
      end
      S_WAIT: begin
        // A result arriving on the timeout cycle still counts as a result
        if (out_valid) begin
          w_m_data_nxt  = Out_OFM;
          w_m_err_nxt   = 1'b0;
          w_m_valid_nxt = 1'b1;
          w_tmo_cnt_nxt = '0;
          w_state_nxt   = S_RESP;
        end else if (r_tmo_cnt == TMO_MAX) begin
          w_m_data_nxt  = '0;
          w_m_err_nxt   = 1'b1;
          w_m_valid_nxt = 1'b1;
          w_tmo_cnt_nxt = '0;
          w_state_nxt   = S_RESP;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
        end
      end
      S_RESP: begin
        if (w_resp_hs) begin
          w_m_valid_nxt  = 1'b0;
          w_load_cnt_nxt = '0;
          w_bit_cnt_nxt  = '0;
          w_tmo_cnt_nxt  = '0;
          w_state_nxt    = S_LOAD;
        end
      end
      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
  end

  // State, counters and all output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_load_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_in_valid  <= 1'b0;
      r_ifm_bits  <= '0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_err     <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_load_cnt  <= w_load_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_tmo_cnt   <= w_tmo_cnt_nxt;
      r_in_valid  <= w_in_valid_nxt;
      r_ifm_bits  <= w_ifm_bits_nxt;
      r_m_valid   <= w_m_valid_nxt;
      r_m_data    <= w_m_data_nxt;
      r_m_err     <= w_m_err_nxt;
      r_proto_err <= w_proto_err_nxt;
    end
  end

  assign in_valid  = r_in_valid;
  assign ifm_bits  = r_ifm_bits;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign m_err     = r_m_err;
  assign proto_err = r_proto_err;

endmodule
